seven_seg_monitor: RTL

//  Receive-side checker for a 7-segment display bus.
//  - Samples the seg pattern, debounces it and decodes it back to a hex nibble.
//  - Infers the count direction (up/down) from successive values and flags

---
 rtl/seven_seg_monitor_if.sv | 32 +++
 rtl/seven_seg_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_monitor_if
// Description : Segment bus plus decoded monitor results for seven_seg_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_monitor_if #(
    parameter int ERR_W = 8
);
    logic [6:0]       seg;
    logic [3:0]       value;
    logic             valid;
    logic             invalid;
    logic             new_value;
    logic             dir_up;
    logic             step_pulse;
    logic             jump_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output seg,
        input  value, valid, invalid, new_value, dir_up,
        input  step_pulse, jump_pulse, err_count
    );

    modport slave (
        input  seg,
        output value, valid, invalid, new_value, dir_up,
        output step_pulse, jump_pulse, err_count
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_monitor.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_monitor
// Description : Debounces a 7-segment bus, decodes it and tracks count steps.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int ERR_W         = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seven_seg_monitor_if.slave bus
);
    localparam int              RUN_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    logic [6:0]       w_seg_hi;
    logic [6:0]       r_seg;
    logic [RUN_W-1:0] r_run;
    logic [6:0]       r_last;
    logic             r_have_last;
    logic             w_accept;
    logic [4:0]       w_dec;
    logic             w_dec_ok;
    logic [3:0]       w_dec_val;
    logic [3:0]       w_prev_up;
    logic [3:0]       w_prev_dn;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_value, w_value_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_invalid, w_invalid_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_new, r_step, r_jump;
    logic             w_step, w_jump, w_err_inc;
    logic [ERR_W-1:0] r_err;

    generate
        if (ACTIVE_LOW != 0) begin : g_invert
            assign w_seg_hi = ~bus.seg;
        end else begin : g_pass
            assign w_seg_hi = bus.seg;
        end
    endgenerate

    // Returns {legal, nibble}; anything outside the 16 glyphs is illegal.
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        case (p)
            7'h3F:   f_decode = 5'h10;
            7'h06:   f_decode = 5'h11;
            7'h5B:   f_decode = 5'h12;
            7'h4F:   f_decode = 5'h13;
            7'h66:   f_decode = 5'h14;
            7'h6D:   f_decode = 5'h15;
            7'h7D:   f_decode = 5'h16;
            7'h07:   f_decode = 5'h17;
            7'h7F:   f_decode = 5'h18;
            7'h6F:   f_decode = 5'h19;
            7'h77:   f_decode = 5'h1A;
            7'h7C:   f_decode = 5'h1B;
            7'h39:   f_decode = 5'h1C;
            7'h5E:   f_decode = 5'h1D;
            7'h79:   f_decode = 5'h1E;
            7'h71:   f_decode = 5'h1F;
            default: f_decode = 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'h00;
            r_run <= '0;
        end else begin
            r_seg <= w_seg_hi;
            if (w_seg_hi == r_seg) begin
                if (r_run != c_RUN_MAX) begin
                    r_run <= r_run + RUN_W'(1);
                end
            end else begin
                r_run <= RUN_W'(1);
            end
        end
    end

    // r_have_last lets the very first stable pattern (even blank) through.
    assign w_accept  = (r_run == c_RUN_MAX) && (!r_have_last || (r_seg != r_last));
    assign w_dec     = f_decode(r_seg);
    assign w_dec_ok  = w_dec[4];
    assign w_dec_val = w_dec[3:0];
    assign w_prev_up = r_value + 4'd1;
    assign w_prev_dn = r_value - 4'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_value_nxt   = r_value;
        w_valid_nxt   = r_valid;
        w_invalid_nxt = r_invalid;
        w_dir_nxt     = r_dir;
        w_step        = 1'b0;
        w_jump        = 1'b0;
        w_err_inc     = 1'b0;
        if (w_accept) begin
            if (!w_dec_ok) begin
                w_valid_nxt   = 1'b0;
                w_invalid_nxt = 1'b1;
                w_err_inc     = 1'b1;
                w_state_nxt   = ST_FAULT;
            end else begin
                w_value_nxt   = w_dec_val;
                w_valid_nxt   = 1'b1;
                w_invalid_nxt = 1'b0;
                w_state_nxt   = ST_TRACK;
                if (r_state == ST_TRACK) begin
                    if (w_dec_val == w_prev_up) begin
                        w_step    = 1'b1;
                        w_dir_nxt = 1'b1;
                    end else if (w_dec_val == w_prev_dn) begin
                        w_step    = 1'b1;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_jump    = 1'b1;
                        w_err_inc = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_value     <= 4'h0;
            r_valid     <= 1'b0;
            r_invalid   <= 1'b0;
            r_dir       <= 1'b1;
            r_new       <= 1'b0;
            r_step      <= 1'b0;
            r_jump      <= 1'b0;
            r_err       <= '0;
            r_have_last <= 1'b0;
            r_last      <= 7'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_value   <= w_value_nxt;
            r_valid   <= w_valid_nxt;
            r_invalid <= w_invalid_nxt;
            r_dir     <= w_dir_nxt;
            r_new     <= w_accept;
            r_step    <= w_step;
            r_jump    <= w_jump;
            if (w_err_inc && (r_err != {ERR_W{1'b1}})) begin
                r_err <= r_err + ERR_W'(1);
            end
            if (w_accept) begin
                r_have_last <= 1'b1;
                r_last      <= r_seg;
            end
        end
    end

    assign bus.value      = r_value;
    assign bus.valid      = r_valid;
    assign bus.invalid    = r_invalid;
    assign bus.new_value  = r_new;
    assign bus.dir_up     = r_dir;
    assign bus.step_pulse = r_step;
    assign bus.jump_pulse = r_jump;
    assign bus.err_count  = r_err;
endmodule
`default_nettype wire
